// File: rtl/half_adder.sv
// Registered, lane-parallel half adder: WIDTH independent lanes, sum = a ^ b, carry = a & b.
// Define HALF_ADDER_CARRY_CNT_EN to add a registered population count of the carry vector.
module half_adder #(
    parameter int WIDTH = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic                         in_valid,
    output logic [WIDTH-1:0]             s,
    output logic [WIDTH-1:0]             c,
`ifdef HALF_ADDER_CARRY_CNT_EN
    output logic [$clog2(WIDTH+1)-1:0]   carry_cnt,
`endif
    output logic                         out_valid
);

    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] carry_next;

    // Lanes are bitwise, so no bit ever influences a neighbour.
    assign sum_next   = a ^ b;
    assign carry_next = a & b;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; s/c simply keep their value when in_valid is low (clock-enabled
    // flops, not latches), which also keeps X on an idle bus out of the registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s         <= '0;
            c         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s <= sum_next;
                c <= carry_next;
            end
        end
    end

`ifdef HALF_ADDER_CARRY_CNT_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next = cnt_next + CNT_W'(carry_next[i]);
        end
    end

    // Counts the freshly computed carries so it lines up with c on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_cnt <= '0;
        end else if (in_valid) begin
            carry_cnt <= cnt_next;
        end
    end
`endif

endmodule

// File: tb/tb_half_adder.sv
// Directed, table-driven bench for half_adder with a 1-lane and an 8-lane instance.
// Carry-count checks are compiled in when HALF_ADDER_CARRY_CNT_EN is defined.
module tb_half_adder;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic [7:0] c;
        int         cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [0:0] a1, b1, s1, c1;
    logic       v1, ov1;
    logic [7:0] a8, b8, s8, c8;
    logic       v8, ov8;
`ifdef HALF_ADDER_CARRY_CNT_EN
    logic [0:0] cnt1;
    logic [3:0] cnt8;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    half_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1),
        .s(s1), .c(c1),
`ifdef HALF_ADDER_CARRY_CNT_EN
        .carry_cnt(cnt1),
`endif
        .out_valid(ov1)
    );

    half_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(v8),
        .s(s8), .c(c8),
`ifdef HALF_ADDER_CARRY_CNT_EN
        .carry_cnt(cnt8),
`endif
        .out_valid(ov8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] s_exp, input logic [7:0] c_exp,
                          input logic ov_exp, input int cnt_exp);
        check({tag, " s8"}, 64'(s8), 64'(s_exp));
        check({tag, " c8"}, 64'(c8), 64'(c_exp));
        check({tag, " out_valid8"}, 64'(ov8), 64'(ov_exp));
`ifdef HALF_ADDER_CARRY_CNT_EN
        check({tag, " carry_cnt8"}, 64'(cnt8), 64'(cnt_exp));
`endif
    endtask

    vec_t tbl1 [4];
    vec_t tbl8 [5];

    initial begin
        tbl1[0] = '{8'h0, 8'h0, 8'h0, 8'h0, 0};
        tbl1[1] = '{8'h0, 8'h1, 8'h1, 8'h0, 0};
        tbl1[2] = '{8'h1, 8'h0, 8'h1, 8'h0, 0};
        tbl1[3] = '{8'h1, 8'h1, 8'h0, 8'h1, 1};

        tbl8[0] = '{8'hF0, 8'hCC, 8'h3C, 8'hC0, 2};
        tbl8[1] = '{8'hAA, 8'h55, 8'hFF, 8'h00, 0};
        tbl8[2] = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 8};
        tbl8[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 0};
        tbl8[4] = '{8'h81, 8'h83, 8'h02, 8'h81, 2};

        // Reset held with active, all-ones inputs.
        a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; v8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset s1", 64'(s1), 64'd0);
            check("reset c1", 64'(c1), 64'd0);
            check("reset out_valid1", 64'(ov1), 64'd0);
            check8("reset", 8'h00, 8'h00, 1'b0, 0);
            #4;
            check8("reset mid-cycle", 8'h00, 8'h00, 1'b0, 0);
            #1;
        end
        step();
        rst_n = 1'b1;
        v8 = 1'b0;

        // WIDTH=1 exhaustive, back-to-back.
        for (int i = 0; i < 4; i++) begin
            a1 = tbl1[i].a[0:0]; b1 = tbl1[i].b[0:0]; v1 = 1'b1;
            step();
            check($sformatf("w1 vec%0d s", i), 64'(s1), 64'(tbl1[i].s[0]));
            check($sformatf("w1 vec%0d c", i), 64'(c1), 64'(tbl1[i].c[0]));
            check($sformatf("w1 vec%0d out_valid", i), 64'(ov1), 64'd1);
`ifdef HALF_ADDER_CARRY_CNT_EN
            check($sformatf("w1 vec%0d carry_cnt", i), 64'(cnt1), 64'(tbl1[i].cnt));
`endif
        end
        v1 = 1'b0;

        // WIDTH=8 vectors, back-to-back.
        for (int i = 0; i < 5; i++) begin
            a8 = tbl8[i].a; b8 = tbl8[i].b; v8 = 1'b1;
            step();
            check8($sformatf("w8 vec%0d", i), tbl8[i].s, tbl8[i].c, 1'b1, tbl8[i].cnt);
        end
        check("w1 idle out_valid", 64'(ov1), 64'd0);
        check("w1 idle hold c", 64'(c1), 64'd1);

        // Hold: idle cycles with changing (and unknown) operands keep the last result.
        a8 = 8'hFF; b8 = 8'h01; v8 = 1'b1;
        step();
        check8("hold load", 8'hFE, 8'h01, 1'b1, 1);
        a8 = 8'h00; b8 = 8'hFF; v8 = 1'b0;
        step();
        check8("hold 1", 8'hFE, 8'h01, 1'b0, 1);
        a8 = 8'hxx; b8 = 8'hxx;
        step();
        check8("hold 2 X inputs", 8'hFE, 8'h01, 1'b0, 1);

        // Reset asserted mid-stream between edges.
        a8 = 8'hFF; b8 = 8'hFF; v8 = 1'b1;
        step();
        check8("pre-reset", 8'h00, 8'hFF, 1'b1, 8);
        #3;
        rst_n = 1'b0;
        #1;
        check8("async reset", 8'h00, 8'h00, 1'b0, 0);
        step();
        check8("reset edge", 8'h00, 8'h00, 1'b0, 0);
        rst_n = 1'b1;
        a8 = 8'hF0; b8 = 8'hCC;
        step();
        check8("post-reset first", 8'h3C, 8'hC0, 1'b1, 2);
        v8 = 1'b0;
        step();
        check8("post-reset idle", 8'h3C, 8'hC0, 1'b0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
